// File: rtl/mem_port_arbiter.sv
// Arbitrates a shared single-port memory between instruction fetch and the data stage.
// Data has priority; a starvation counter forces a fetch after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        stall
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          fetch_wins;
  logic          data_wins;
  logic          grant_fetch;
  logic          grant_data;

  // Priority is resolved on raw requests first; a requester whose ack is high
  // is then masked, so its ack cycle becomes a turnaround unless the other side wins.
  assign starved     = (starve_cnt == STARVE_LIMIT);
  assign fetch_wins  = if_req & (starved | ~d_req);
  assign data_wins   = d_req & ~fetch_wins;
  assign grant_fetch = fetch_wins & ~if_ack;
  assign grant_data  = data_wins & ~d_ack;

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fetch) begin
            state      <= FETCH;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            starve_cnt <= '0;
          end else if (grant_data) begin
            state   <= DATA;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (if_req && !starved) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end
        end
        FETCH: begin
          if (m_ready) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= m_rdata;
          end
        end
        DATA: begin
          if (m_ready) begin
            state <= IDLE;
            m_req <= 1'b0;
            d_ack <= 1'b1;
            // Stores complete without touching the last load result.
            if (!m_we) begin
              d_rdata <= m_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for simultaneous requests, starvation and reset mid-access.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        stall;

  logic        auto_mode;
  logic        ready_man;
  logic [31:0] rdata_man;

  int checks = 0;
  int errors = 0;

  // Auto mode: memory answers in the first m_req cycle with a data word derived from the address.
  assign m_ready = auto_mode ? m_req : ready_man;
  assign m_rdata = auto_mode ? (m_addr ^ 32'h5A5A_0000) : rdata_man;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    ready_man = 1'b0;
    rdata_man = v.rdata;
    if (v.is_fetch) begin
      if_req  = 1'b1;
      if_addr = v.addr;
      d_we    = 1'b1;
      d_wdata = v.wdata;
    end else begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end
    #1;
    chk("stall_on_request", 32'(stall), 32'd1);
    tick();
    chk("grant_m_req", 32'(m_req), 32'd1);
    chk("grant_m_addr", m_addr, v.addr);
    chk("grant_m_we", 32'(m_we), 32'(v.exp_we));
    chk("grant_m_wdata", m_wdata, v.exp_wdata);
    // Requester inputs change after the grant; latched outputs must not follow.
    if_addr   = ~v.addr;
    d_addr    = ~v.addr;
    d_wdata   = ~v.wdata;
    d_we      = ~v.we;
    ready_man = (v.waits == 0);
    for (int w = 0; w < v.waits; w++) begin
      tick();
      chk("wait_m_req", 32'(m_req), 32'd1);
      chk("wait_m_addr", m_addr, v.addr);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_no_ack", 32'({if_ack, d_ack}), 32'd0);
      if (w == v.waits - 1) ready_man = 1'b1;
    end
    tick();
    chk("ack_if", 32'(if_ack), 32'(v.is_fetch));
    chk("ack_d", 32'(d_ack), 32'(!v.is_fetch));
    chk("ack_m_req_low", 32'(m_req), 32'd0);
    chk("ack_stall_low", 32'(stall), 32'd0);
    chk("if_rdata", if_rdata, v.exp_if_rdata);
    chk("d_rdata", d_rdata, v.exp_d_rdata);
    $display("txn %0d: %s addr=%h we=%0d waits=%0d if_rdata=%h d_rdata=%h",
             idx, v.is_fetch ? "fetch" : "data", v.addr, v.we, v.waits, if_rdata, d_rdata);
    if_req    = 1'b0;
    d_req     = 1'b0;
    ready_man = 1'b0;
    tick();
    chk("ack_pulse_one_cycle", 32'({if_ack, d_ack}), 32'd0);
  endtask

  task automatic starve_round(input int round);
    int  n_dack;
    bit  done;
    n_dack = 0;
    done   = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      if (d_ack) n_dack++;
      if (if_ack) done = 1'b1;
    end
    chk("starve_fetch_granted", 32'(done), 32'd1);
    chk("starve_dack_count", 32'(n_dack), 32'd4);
    $display("txn starve round %0d: d_acks before fetch=%0d", round, n_dack);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h00A0_0093, 0,
                1'b0, 32'h0, 32'h00A0_0093, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0BAD_F00D, 32'h1234_5678, 0,
                1'b0, 32'h0BAD_F00D, 32'h00A0_0093, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h5555_5555, 1,
                1'b1, 32'hDEAD_BEEF, 32'h00A0_0093, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0014, 32'h7777_7777, 32'hABCD_0001, 2,
                1'b0, 32'h0, 32'hABCD_0001, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 5,
                1'b0, 32'h0, 32'hABCD_0001, 32'hCAFE_F00D};

    rst_n = 1'b0; auto_mode = 1'b0; ready_man = 1'b0; rdata_man = '0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // m_ready while idle must not produce an ack or a request.
    ready_man = 1'b1;
    tick();
    tick();
    chk("idle_ready_no_ack", 32'({if_ack, d_ack}), 32'd0);
    chk("idle_ready_no_req", 32'(m_req), 32'd0);
    ready_man = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      apply_vec(i, vecs[i]);
    end

    // Simultaneous fetch and store: data first, then fetch.
    auto_mode = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("sim_data_first_addr", m_addr, 32'h200);
    chk("sim_data_first_we", 32'(m_we), 32'd1);
    chk("sim_data_first_wdata", m_wdata, 32'hDEAD_BEEF);
    tick();
    chk("sim_d_ack", 32'(d_ack), 32'd1);
    chk("sim_if_ack_low", 32'(if_ack), 32'd0);
    d_req = 1'b0;
    tick();
    chk("sim_fetch_req", 32'(m_req), 32'd1);
    chk("sim_fetch_addr", m_addr, 32'h40);
    chk("sim_fetch_we", 32'(m_we), 32'd0);
    chk("sim_fetch_wdata", m_wdata, 32'h0);
    tick();
    chk("sim_if_ack", 32'(if_ack), 32'd1);
    chk("sim_if_rdata", if_rdata, 32'h5A5A_0040);
    $display("txn simultaneous: store then fetch, if_rdata=%h", if_rdata);
    if_req = 1'b0;
    tick();

    // Starvation: fetch held, data always requesting; two rounds show the counter clears.
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    starve_round(1);
    starve_round(2);
    if_req = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        if (d_ack) seen = 1'b1;
      end
      chk("starve_drain_dack", 32'(seen), 32'd1);
    end
    chk("starve_d_rdata", d_rdata, 32'h5A5A_0400);
    d_req = 1'b0;
    tick();

    // Reset in the middle of a stalled load.
    auto_mode = 1'b0; ready_man = 1'b0; rdata_man = 32'h600D_F00D;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    tick();
    chk("rmid_granted", 32'(m_req), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmid_m_req_async", 32'(m_req), 32'd0);
    chk("rmid_m_addr_async", m_addr, 32'h0);
    chk("rmid_d_rdata_async", d_rdata, 32'h0);
    chk("rmid_if_rdata_async", if_rdata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    ready_man = 1'b1;
    tick();
    chk("rmid_no_stale_ack", 32'(d_ack), 32'd0);
    chk("rmid_regrant_req", 32'(m_req), 32'd1);
    chk("rmid_regrant_addr", m_addr, 32'h500);
    tick();
    chk("rmid_d_ack", 32'(d_ack), 32'd1);
    chk("rmid_d_rdata", d_rdata, 32'h600D_F00D);
    $display("txn reset-mid-access: regranted load, d_rdata=%h", d_rdata);
    d_req = 1'b0; ready_man = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while fetch is pending.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch address (PC).
REQ-006 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-007 SHALL have port if_ack  output  1  one-cycle pulse; fetch done, if_rdata valid.
REQ-008 SHALL have port d_req  input  1  data-stage request, held until d_ack.
REQ-009 SHALL have port d_we  input  1  1=write, 0=read.
REQ-010 SHALL have port d_addr  input  32  data address (EX/MEM ALU result).
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_rdata  output  32  load data.
REQ-013 SHALL have port d_ack  output  1  one-cycle pulse; data access done.
REQ-014 SHALL have port m_req  output  1  request to shared single-port memory.
REQ-015 SHALL have port m_we  output  1  memory write enable.
REQ-016 SHALL have port m_addr  output  32  memory address.
REQ-017 SHALL have port m_wdata  output  32  memory write data.
REQ-018 SHALL have port m_rdata  input  32  memory read data, valid when m_ready=1.
REQ-019 SHALL have port m_ready  input  1  memory completes current access this cycle.
REQ-020 SHALL have port stall  output  1  pipeline stall (feeds PC/IF-ID clock gate).

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, DATA; exactly one memory access outstanding.
REQ-022 IDLE: grant decided from requests sampled at clock edge; no grant -> remain IDLE.
REQ-023 Priority: data over fetch, except fetch wins when if_req=1 and starve_cnt==STARVE_MAX.
REQ-024 starve_cnt: +1 on data grant while if_req=1, saturate at STARVE_MAX; clear on fetch grant; unchanged otherwise.
REQ-025 On grant, addr/we/wdata SHALL be latched into m_addr/m_we/m_wdata and m_req=1 from the next cycle; requester input changes after grant ignored.
REQ-026 Fetch grants SHALL drive m_we=0 and m_wdata=0.
REQ-027 FETCH/DATA: hold m_req and latched outputs until a cycle with m_ready=1; m_ready while IDLE ignored.
REQ-028 On m_ready=1: next cycle state=IDLE, m_req=0, ack of granted requester =1 for exactly one cycle.
REQ-029 Read completion SHALL register m_rdata into if_rdata/d_rdata, held until next completion for that requester; write completion leaves d_rdata unchanged.
REQ-030 A requester SHALL NOT be granted in the cycle its ack is high; the other requester may be.
REQ-031 Minimum latency request -> ack: 3 cycles (grant edge, m_ready in first m_req cycle, ack); +1 cycle per m_ready=0 cycle.
REQ-032 stall SHALL be combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-033 m_req/m_we/m_addr/m_wdata/acks SHALL be registered (no combinational input-to-output path except stall).

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, starve_cnt=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0.
REQ-035 Reset mid-transaction SHALL abandon the access; no ack after release; first grant re-arbitrates from IDLE.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x10, m_ready=1 whenever m_req, m_rdata=0x00A00093 -> m_addr=0x10, m_we=0, if_ack pulse 3rd cycle, if_rdata=0x00A00093.
REQ-037 Simultaneous: if_req=d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> data granted first (m_we=1, m_wdata=0xDEADBEEF), d_ack, then fetch granted, if_ack.
REQ-038 Starvation: if_req held, d_req reasserted after each d_ack, STARVE_MAX=4 -> exactly 4 d_acks, then fetch grant, starve_cnt=0.
REQ-039 Wait states: m_ready=0 for 5 cycles on a load -> m_req/m_addr stable, stall=1 throughout, d_ack on cycle 8, d_rdata=m_rdata sampled at m_ready.
REQ-040 Reset mid-access: rst_n=0 during DATA with m_ready=0 -> m_req=0 same cycle, no d_ack after rst_n=1, new grant from IDLE.
